// File: rtl/muladd_dot_seq.sv
// Sequencer driving one MULADD BEL (ConfigBits 6'b101000: ACC feedback, unsigned,
// Q = ACC) as an unsigned 8x8 dot-product engine with valid/ready job and result ports.
module muladd_dot_seq #(
    parameter int LEN_W = 5
) (
    input  logic             UserCLK,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [19:0]      res_q,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_clr,
    input  logic [19:0]      mac_q
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [19:0]      res_d;
    logic             valid_q, valid_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;
    logic             in_accum;
    logic             xfer;

    assign in_accum = (state_q == S_ACCUM);
    // Abort blocks the in-flight pair, so it must neither handshake nor reach the BEL.
    assign in_ready = in_accum & ~abort;
    assign xfer     = in_ready & in_valid;

    assign mac_a     = xfer ? in_a : 8'd0;
    assign mac_b     = xfer ? in_b : 8'd0;
    assign mac_clr   = clr_q;
    assign busy      = busy_q;
    assign res_valid = valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = valid_q;
        clr_d   = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            cnt_d   = len;
                            clr_d   = 1'b1;
                            state_d = S_CLEAR;
                        end else begin
                            res_d   = 20'd0;
                            valid_d = 1'b1;
                            state_d = S_RESULT;
                        end
                    end
                end
                S_CLEAR: begin
                    state_d = S_ACCUM;
                end
                S_ACCUM: begin
                    if (xfer) begin
                        cnt_d = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last product landed in ACC at the previous edge; Q now shows it.
                    res_d   = mac_q;
                    valid_d = 1'b1;
                    state_d = S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= 20'd0;
            valid_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_muladd_dot_seq.sv
// Bench for muladd_dot_seq: a behavioural MULADD (ConfigBits 6'b101000) closes the loop,
// and each job's result is compared with a plain sum-of-products modulo 2^20.
module tb_muladd_dot_seq;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             res_valid;
    logic             res_ready;
    logic [19:0]      res_q;
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_clr;
    logic [19:0]      acc = 20'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    // Behavioural MULADD: unregistered A/B, ACC feedback addend, unsigned, Q = ACC.
    always @(posedge clk) begin
        if (mac_clr) acc <= 20'd0;
        else         acc <= acc + ({12'd0, mac_a} * {12'd0, mac_b});
    end

    muladd_dot_seq #(.LEN_W(LEN_W)) dut (
        .UserCLK  (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_q    (res_q),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_clr  (mac_clr),
        .mac_q    (acc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] model_sum();
        longint unsigned s = 0;
        for (int i = 0; i < qa.size(); i++) s += longint'(qa[i]) * longint'(qb[i]);
        return 20'(s % 64'd1048576);
    endfunction

    // Runs the job in qa/qb from IDLE until res_valid rises; returns measurements.
    task automatic drive_job(input int bubbles, output int edges, output int hs,
                             output int clr_cnt, output int bub_nz, output logic to);
        int idx = 0;
        int gap = 0;
        logic fire;
        edges = 0; hs = 0; clr_cnt = 0; bub_nz = 0; to = 1'b1;
        start = 1'b1;
        len   = LEN_W'(qa.size());
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid = (idx < qa.size()) && (gap == 0);
            if (in_valid) begin
                in_a = qa[idx];
                in_b = qb[idx];
            end else begin
                in_a = 8'($urandom_range(1, 255));
                in_b = 8'($urandom_range(1, 255));
            end
            #1;
            if (mac_clr) clr_cnt++;
            fire = in_valid && in_ready;
            if (!in_valid && in_ready && (mac_a != 8'd0 || mac_b != 8'd0)) bub_nz++;
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
            if (fire) begin
                idx++;
                hs++;
                gap = bubbles;
            end else if (in_ready && gap > 0) begin
                gap--;
            end
            if (res_valid) begin
                to = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job();
        res_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0;
        in_a = 8'd0; in_b = 8'd0; res_ready = 1'b0;
        #2;
        n_checks++;
        if ({busy, res_valid, in_ready, mac_clr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, res_valid, in_ready, mac_clr});
        end
        n_checks++;
        if ({res_q, mac_a, mac_b} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_data: got res_q=%0d mac_a=%0d mac_b=%0d expected all 0", res_q, mac_a, mac_b);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e, hs, clr, nz; logic to; logic [19:0] exp_q;
        qa = '{8'd2, 8'd4, 8'd10};
        qb = '{8'd3, 8'd5, 8'd10};
        exp_q = model_sum();
        res_ready = 1'b1;
        drive_job(0, e, hs, clr, nz, to);
        n_checks++;
        if (to || res_q !== exp_q) begin
            n_fail++;
            $display("FAIL basic_res_q: got %0d (timeout=%0b) expected %0d", res_q, to, exp_q);
        end
        n_checks++;
        if (e !== 6) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges expected 6", e);
        end
        n_checks++;
        if (clr !== 1) begin
            n_fail++;
            $display("FAIL basic_clr_once: got %0d expected 1", clr);
        end
        finish_job();
        n_checks++;
        if ({res_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_release: got valid,busy=%b expected 00", {res_valid, busy});
        end
    endtask

    task automatic test_bubbles();
        int e, hs, clr, nz; logic to; logic [19:0] exp_q;
        qa = '{8'd2, 8'd4, 8'd10};
        qb = '{8'd3, 8'd5, 8'd10};
        exp_q = model_sum();
        res_ready = 1'b1;
        drive_job(2, e, hs, clr, nz, to);
        n_checks++;
        if (to || res_q !== exp_q) begin
            n_fail++;
            $display("FAIL bubble_res_q: got %0d (timeout=%0b) expected %0d", res_q, to, exp_q);
        end
        n_checks++;
        if (hs !== 3) begin
            n_fail++;
            $display("FAIL bubble_handshakes: got %0d expected 3", hs);
        end
        n_checks++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL bubble_mac_zero: got %0d nonzero bubble cycles expected 0", nz);
        end
        finish_job();
    endtask

    task automatic test_zero_and_backpressure();
        int e, hs, clr, nz; logic to; logic [19:0] exp_q;
        qa.delete(); qb.delete();
        res_ready = 1'b1;
        drive_job(0, e, hs, clr, nz, to);
        n_checks++;
        if (to || res_q !== 20'd0 || e !== 1) begin
            n_fail++;
            $display("FAIL zero_len: got res_q=%0d edges=%0d (timeout=%0b) expected 0 and 1", res_q, e, to);
        end
        finish_job();
        qa = '{8'd255, 8'd1};
        qb = '{8'd255, 8'd1};
        exp_q = model_sum();
        res_ready = 1'b0;
        drive_job(0, e, hs, clr, nz, to);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = LEN_W'($urandom_range(1, 31));
            tick();
            n_checks++;
            if (to || res_q !== exp_q || res_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got res_q=%0d valid=%b busy=%b expected %0d 1 1",
                         i, res_q, res_valid, busy, exp_q);
            end
        end
        start = 1'b0;
        finish_job();
        tick();
        n_checks++;
        if ({res_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_not_queued: got valid,busy=%b expected 00", {res_valid, busy});
        end
    endtask

    task automatic test_wrap();
        int e, hs, clr, nz; logic to; logic [19:0] exp_q;
        qa.delete(); qb.delete();
        for (int i = 0; i < 31; i++) begin
            qa.push_back(8'd255);
            qb.push_back(8'd255);
        end
        exp_q = model_sum();
        res_ready = 1'b1;
        drive_job(0, e, hs, clr, nz, to);
        n_checks++;
        if (to || res_q !== exp_q || e !== 34) begin
            n_fail++;
            $display("FAIL wrap_res_q: got %0d edges=%0d (timeout=%0b) expected %0d edges=34", res_q, e, to, exp_q);
        end
        finish_job();
    endtask

    task automatic test_random_jobs();
        int e, hs, clr, nz, n, bub; logic to; logic [19:0] exp_q;
        for (int j = 0; j < 8; j++) begin
            n   = $urandom_range(1, 31);
            bub = $urandom_range(0, 2);
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(8'($urandom));
                qb.push_back(8'($urandom));
            end
            exp_q = model_sum();
            res_ready = 1'b1;
            drive_job(bub, e, hs, clr, nz, to);
            n_checks++;
            if (to || res_q !== exp_q || hs !== n || nz !== 0) begin
                n_fail++;
                $display("FAIL random_job[%0d]: got res_q=%0d hs=%0d nz=%0d (timeout=%0b) expected %0d hs=%0d nz=0",
                         j, res_q, hs, nz, to, exp_q, n);
            end
            n_checks++;
            if (bub == 0 && e !== n + 3) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got %0d edges expected %0d", j, e, n + 3);
            end
            finish_job();
        end
    endtask

    task automatic test_abort();
        int e, hs, clr, nz; logic to; logic [19:0] exp_q, held;
        held = res_q;
        start = 1'b1; len = LEN_W'(4);
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_a = 8'd13; in_b = 8'd11;
        tick();
        in_a = 8'd17; in_b = 8'd19; abort = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_ready: got %b expected 0", in_ready);
        end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({busy, res_valid} !== 2'b00 || res_q !== held) begin
            n_fail++;
            $display("FAIL abort_idle: got busy,valid=%b res_q=%0d expected 00 res_q=%0d", {busy, res_valid}, res_q, held);
        end
        qa = '{8'd7};
        qb = '{8'd7};
        exp_q = model_sum();
        res_ready = 1'b1;
        drive_job(0, e, hs, clr, nz, to);
        n_checks++;
        if (to || res_q !== exp_q) begin
            n_fail++;
            $display("FAIL abort_next_job: got %0d (timeout=%0b) expected %0d", res_q, to, exp_q);
        end
        finish_job();
    endtask

    task automatic test_reset_mid_job();
        int e, hs, clr, nz; logic to; logic [19:0] exp_q;
        start = 1'b1; len = LEN_W'(4);
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || mac_a !== 8'd9 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got ready=%b mac_a=%0d busy=%b expected 1 9 1", in_ready, mac_a, busy);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, res_valid, in_ready, mac_clr} !== 4'b0000 || {res_q, mac_a, mac_b} !== 36'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got busy=%b valid=%b ready=%b clr=%b res_q=%0d mac_a=%0d mac_b=%0d expected all 0",
                     busy, res_valid, in_ready, mac_clr, res_q, mac_a, mac_b);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        qa = '{8'd200, 8'd3};
        qb = '{8'd100, 8'd50};
        exp_q = model_sum();
        res_ready = 1'b1;
        drive_job(0, e, hs, clr, nz, to);
        n_checks++;
        if (to || res_q !== exp_q) begin
            n_fail++;
            $display("FAIL midrst_recover: got %0d (timeout=%0b) expected %0d", res_q, to, exp_q);
        end
        finish_job();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_zero_and_backpressure();
        test_wrap();
        test_random_jobs();
        test_abort();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muladd_dot_seq.md
Name: muladd_dot_seq

Overview:
- Sequencer that runs one MULADD BEL as an unsigned 8x8 dot-product engine.
- Fixed MULADD configuration it drives: ConfigBits = 6'b101000. That means unregistered A, B and C, ACC feedback as addend, unsigned product, and Q = ACC.
- Accepts a job of N element pairs over a valid/ready stream and drives the BEL's A, B and clr pins.
- Captures the accumulated 20-bit result from Q and returns it on a valid/ready result port.
- Sits between fabric logic (the requester) and the MULADD BEL in the same tile group.

Parameters:
- LEN_W, 5, width of the job-length input; maximum job is 2^LEN_W-1 pairs.

Ports:
- UserCLK  in  1  fabric user clock; all state on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of element pairs in the job; sampled with start.
- abort  in  1  cancels the current job from any non-IDLE state.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  element pair valid.
- in_ready  out  1  element pair accepted (high only in ACCUM).
- in_a  in  8  element of operand A.
- in_b  in  8  element of operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_q  out  20  dot-product result, registered.
- mac_a  out  8  to MULADD A7..A0.
- mac_b  out  8  to MULADD B7..B0.
- mac_clr  out  1  to MULADD clr.
- mac_q  in  20  from MULADD Q19..Q0 (equals ACC).

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IDLE, cnt = 0, res_q = 0.
  - res_valid, in_ready, mac_clr and busy all 0.
  - mac_a = mac_b = 0.
- mac_a/mac_b drive rule:
  - In ACCUM: mac_a = in_valid ? in_a : 0, and likewise mac_b from in_b. This path is combinational.
  - In every other state: mac_a = mac_b = 0, so ACC adds zero.
- IDLE:
  - start=1 with len != 0: cnt <= len, go to CLEAR.
  - start=1 with len == 0: res_q <= 0, go to RESULT.
  - start=0: stay in IDLE.
- CLEAR: mac_clr = 1 for exactly one cycle, then go to ACCUM. ACC is 0 at the following edge.
- ACCUM:
  - in_ready = 1.
  - Each cycle with in_valid=1 transfers one pair; the BEL adds in_a*in_b into ACC at that edge; cnt decrements.
  - Cycles with in_valid=0 are bubbles: nothing is consumed and ACC is unchanged.
  - A transfer while cnt == 1 moves to DRAIN.
- DRAIN: one cycle. mac_q now holds the final ACC; res_q <= mac_q; go to RESULT.
- RESULT:
  - res_valid = 1; res_q is held stable.
  - On res_valid & res_ready: go to IDLE; res_valid drops the next cycle.
- Latency: with back-to-back valid pairs, start sampled at edge 0 gives res_valid high after edge N+3.
- start while busy: ignored; no queueing.
- abort:
  - Takes priority over every other transition in the same cycle.
  - Next state is IDLE; res_valid is cleared; res_q is unchanged.
  - The in-flight pair in that cycle is not consumed (in_ready is forced to 0 when abort=1).
  - ACC is left dirty; the next job's CLEAR resets it.
- Arithmetic: unsigned modulo 2^20. Overflow wraps silently with no flag.
- Asynchronous rst mid-job: returns to IDLE immediately. ACC in the BEL is not reset by this block.

Test Plan:
- Basic job: len=3, pairs (2,3),(4,5),(10,10) back-to-back, res_ready=1 → res_q=126; res_valid asserted 6 edges after start; mac_clr high exactly once.
- Bubbles: same job with in_valid low for 2 cycles between each pair → res_q=126; mac_a/mac_b are 0 during the bubbles; exactly 3 handshakes occur.
- Zero length and backpressure: len=0 → res_q=0 and res_valid high after one edge. Then a job of len=2 with pairs (255,255),(1,1) and res_ready held low for 5 cycles → res_q=65026 stays stable with res_valid high; start pulses during that window are ignored.
- Wrap-around: len=31, all pairs (255,255) → res_q=967199 (2015775 mod 2^20).
- Abort and reset: abort in ACCUM after 1 of 4 pairs → IDLE next cycle with busy=0. The following job len=1 with pair (7,7) → res_q=49, proving CLEAR removed the stale ACC. rst asserted mid-ACCUM → all outputs take their reset values immediately, with no clock edge required.
- Bench model: a behavioural MULADD with ConfigBits=6'b101000 serves as the reference in all scenarios.
